// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB writes first, MDU results wait in an in-order buffer and drain into idle cycles.
// Optional starvation guard under RF_ARB_STARVE_GUARD_EN forces an MDU grant (and stalls WB) after STARVE_LIMIT denials.
module rf_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wb_valid,
  input  logic [ADDR_W-1:0]                  wb_dest,
  input  logic [DATA_W-1:0]                  wb_data,
  output logic                               wb_stall,
  input  logic                               mdu_valid,
  output logic                               mdu_ready,
  input  logic [ADDR_W-1:0]                  mdu_dest,
  input  logic [DATA_W-1:0]                  mdu_data,
  output logic                               rf_we,
  output logic [ADDR_W-1:0]                  rf_dest,
  output logic [DATA_W-1:0]                  rf_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

  logic              ent_vld  [FIFO_DEPTH];
  logic [ADDR_W-1:0] ent_dest [FIFO_DEPTH];
  logic [DATA_W-1:0] ent_data [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;

  logic head_valid, wb_req, force_grant;
  logic grant_wb, grant_head, push, pop;

  assign head_valid = (count != '0) && ent_vld[rd_ptr];
  assign wb_req     = wb_valid && (wb_dest != '0);
  assign mdu_ready  = !reset && (count < DEPTH_C);
  // Dest-0 results complete the handshake but are dropped here.
  assign push       = mdu_valid && mdu_ready && (mdu_dest != '0);
  assign pop        = grant_head || ((count != '0) && !ent_vld[rd_ptr]);
  assign fifo_count = count;
  assign busy       = (count != '0);

  always_comb begin
    grant_wb   = 1'b0;
    grant_head = 1'b0;
    if (!reset) begin
      if (force_grant)     grant_head = 1'b1;
      else if (wb_req)     grant_wb   = 1'b1;
      else if (head_valid) grant_head = 1'b1;
    end
    rf_we   = grant_wb || grant_head;
    rf_dest = '0;
    rf_data = '0;
    if (grant_wb) begin
      rf_dest = wb_dest;
      rf_data = wb_data;
    end else if (grant_head) begin
      rf_dest = ent_dest[rd_ptr];
      rf_data = ent_data[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ent_vld[i]  <= 1'b0;
        ent_dest[i] <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      // A granted WB write is younger than every buffered result, so same-dest entries are stale.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (grant_wb && ent_vld[i] && (ent_dest[i] == wb_dest)) ent_vld[i] <= 1'b0;
      end
      if (pop) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
      end
      if (push) begin
        ent_vld[wr_ptr]  <= 1'b1;
        ent_dest[wr_ptr] <= mdu_dest;
        ent_data[wr_ptr] <= mdu_data;
        wr_ptr           <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef RF_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;

  assign force_grant = head_valid && (starve_cnt == LIMIT_C);
  assign wb_stall    = !reset && force_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          starve_cnt <= '0;
    else if (grant_head || !head_valid) starve_cnt <= '0;
    else if (starve_cnt != LIMIT_C)     starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign force_grant = 1'b0;
  assign wb_stall    = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: queue-based reference model checked every cycle plus directed literal checks.
module tb_rf_write_arbiter;

`ifdef RF_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int DEPTH  = 2;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_stall, mdu_valid, mdu_ready, rf_we, busy;
  logic [4:0]  wb_dest, mdu_dest, rf_dest;
  logic [31:0] wb_data, mdu_data, rf_data;
  logic [1:0]  fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .wb_stall(wb_stall),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_dest(mdu_dest), .mdu_data(mdu_data),
    .rf_we(rf_we), .rf_dest(rf_dest), .rf_data(rf_data),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv(bit wv, int wd, int wx, bit mv, int md, int mx);
    wb_valid  = wv;
    wb_dest   = 5'(wd);
    wb_data   = 32'(wx);
    mdu_valid = mv;
    mdu_dest  = 5'(md);
    mdu_data  = 32'(mx);
  endtask

  task automatic pos;
    @(posedge clk);
    #1;
  endtask

  // Reference model: ordered list of buffered results, each with a live flag.
  typedef struct {
    bit          v;
    logic [4:0]  d;
    logic [31:0] x;
  } ent_t;

  ent_t q[$];
  int   starve = 0;

  always @(negedge clk) begin
    bit hv, frc, wbr, gw, gh, acc, pp;
    int sz;
    if (reset) begin
      q.delete();
      starve = 0;
      chk("m_rst_we", rf_we, 0);
      chk("m_rst_rdy", mdu_ready, 0);
      chk("m_rst_stall", wb_stall, 0);
      chk("m_rst_cnt", fifo_count, 0);
    end else begin
      sz  = q.size();
      hv  = (sz > 0) && q[0].v;
      frc = GUARD && (starve == STARVE) && hv;
      wbr = wb_valid && (wb_dest != 0);
      gh  = frc || (!wbr && hv);
      gw  = !frc && wbr;
      chk("m_we", rf_we, gw || gh);
      if (gw) begin
        chk("m_wb_dest", rf_dest, wb_dest);
        chk("m_wb_data", rf_data, wb_data);
      end
      if (gh) begin
        chk("m_hd_dest", rf_dest, q[0].d);
        chk("m_hd_data", rf_data, q[0].x);
      end
      chk("m_stall", wb_stall, frc);
      chk("m_rdy", mdu_ready, sz < DEPTH);
      chk("m_cnt", fifo_count, sz);
      chk("m_busy", busy, sz != 0);
      acc = mdu_valid && (sz < DEPTH);
      pp  = gh || ((sz > 0) && !q[0].v);
      if (gw) foreach (q[i]) if (q[i].d == wb_dest) q[i].v = 1'b0;
      if (pp) void'(q.pop_front());
      if (acc && mdu_dest != 0) q.push_back('{v: 1'b1, d: mdu_dest, x: mdu_data});
      starve = (gh || !hv) ? 0 : starve + 1;
    end
  end

  initial begin
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_rdy", mdu_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); chk("rdy_after_rst", mdu_ready, 1); pos;

    // WB only
    drv(1, 5, 'hA5, 0, 0, 0);
    @(negedge clk);
    chk("wb_we", rf_we, 1); chk("wb_dest", rf_dest, 5); chk("wb_data", rf_data, 'hA5); chk("wb_cnt", fifo_count, 0);
    pos;

    // MDU drain in idle cycles
    drv(0, 0, 0, 1, 7, 'h1234);
    @(negedge clk); chk("push_we", rf_we, 0); pos;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drain_cnt", fifo_count, 1); chk("drain_we", rf_we, 1);
    chk("drain_dest", rf_dest, 7); chk("drain_data", rf_data, 'h1234);
    pos;
    @(negedge clk); chk("drain_cnt0", fifo_count, 0); chk("drain_we0", rf_we, 0); pos;

    // Backpressure with WB busy
    drv(1, 1, 1, 1, 8, 'h88);
    @(negedge clk); pos;
    drv(1, 1, 1, 1, 10, 'hAA);
    @(negedge clk); chk("bp_cnt1", fifo_count, 1); pos;
    drv(1, 1, 1, 1, 11, 'hBB);
    @(negedge clk);
    chk("bp_cnt2", fifo_count, 2); chk("bp_rdy", mdu_ready, 0); chk("bp_wb", rf_dest, 1);
    pos;
    @(negedge clk); chk("bp_hold", fifo_count, 2); pos;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("bp_first", rf_dest, 8); chk("bp_cnt_a", fifo_count, 2); pos;
    @(negedge clk); chk("bp_second", rf_dest, 10); chk("bp_cnt_b", fifo_count, 1); pos;
    @(negedge clk); chk("bp_empty", fifo_count, 0); chk("bp_we0", rf_we, 0); pos;

    // Cancel by younger WB write
    drv(1, 2, 'h2, 1, 9, 'h11);
    @(negedge clk); pos;
    drv(1, 9, 'h22, 0, 0, 0);
    @(negedge clk);
    chk("cx_we", rf_we, 1); chk("cx_dest", rf_dest, 9); chk("cx_data", rf_data, 'h22); chk("cx_cnt", fifo_count, 1);
    pos;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("cx_drop_we", rf_we, 0); chk("cx_drop_cnt", fifo_count, 1); pos;
    @(negedge clk); chk("cx_cnt0", fifo_count, 0); pos;

    // Destination 0 on both sources
    drv(1, 0, 'hEE, 1, 0, 'hDD);
    @(negedge clk); chk("z_we", rf_we, 0); chk("z_rdy", mdu_ready, 1); pos;
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("z_cnt", fifo_count, 0); chk("z_we2", rf_we, 0); pos;

    // Starvation
    drv(1, 3, 'h33, 1, 7, 'h77);
    @(negedge clk); pos;
    drv(1, 3, 'h33, 0, 0, 0);
    repeat (4) begin
      @(negedge clk); chk("sv_wb", rf_dest, 3); chk("sv_nostall", wb_stall, 0); pos;
    end
    @(negedge clk);
    chk("sv_force_dest", rf_dest, GUARD ? 7 : 3);
    chk("sv_force_stall", wb_stall, GUARD);
    pos;
    @(negedge clk);
    chk("sv_resume", rf_dest, 3); chk("sv_cnt", fifo_count, GUARD ? 0 : 1);
    pos;
    repeat (3) begin @(negedge clk); pos; end
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sv_idle_we", rf_we, !GUARD);
    if (!GUARD) chk("sv_late_dest", rf_dest, 7);
    pos;
    @(negedge clk); chk("sv_end_cnt", fifo_count, 0); pos;

    // Reset mid-operation
    drv(1, 4, 'h44, 1, 12, 'hC);
    @(negedge clk); pos;
    drv(1, 4, 'h44, 1, 13, 'hD);
    @(negedge clk); chk("rm_cnt1", fifo_count, 1); pos;
    drv(1, 4, 'h44, 0, 0, 0);
    @(negedge clk); chk("rm_cnt2", fifo_count, 2); pos;
    reset = 1'b1;
    @(negedge clk);
    chk("rm_cnt0", fifo_count, 0); chk("rm_we", rf_we, 0); chk("rm_rdy", mdu_ready, 0);
    chk("rm_stall", wb_stall, 0); chk("rm_busy", busy, 0);
    pos;
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    repeat (3) begin
      @(negedge clk); chk("rm_flushed_we", rf_we, 0); chk("rm_flushed_cnt", fifo_count, 0); pos;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Arbitrates the register file's single write port between the pipeline writeback (WB) stage and the multi-cycle multiply/divide unit (MDU). MDU results are buffered in a small in-order FIFO and drained into free write-port cycles. WB keeps priority. A buffered result is cancelled if a younger WB write targets the same register. The block sits between WB/MDU and the register file write port (write enable, destination, data).

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 2, MDU result buffer entries (≥1)
- STARVE_LIMIT, 4, consecutive denied cycles before a forced MDU grant (starvation guard only)

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- wb_valid  in  1  WB stage requests a register write
- wb_dest  in  ADDR_W  WB destination register
- wb_data  in  DATA_W  WB write data
- wb_stall  out  1  WB must hold its request this cycle (forced MDU grant)
- mdu_valid  in  1  MDU result available
- mdu_ready  out  1  FIFO can accept an MDU result
- mdu_dest  in  ADDR_W  MDU destination register
- mdu_data  in  DATA_W  MDU result
- rf_we  out  1  register file write enable
- rf_dest  out  ADDR_W  register file write destination
- rf_data  out  DATA_W  register file write data
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied FIFO entries, including cancelled entries
- busy  out  1  fifo_count != 0

## Operation
- The FIFO holds {valid, dest, data} per entry, plus read/write pointers that wrap modulo FIFO_DEPTH.
- Push condition: mdu_valid && mdu_ready.
  - mdu_ready = (fifo_count < FIFO_DEPTH), taken from the registered count.
  - A push into a full FIFO is never accepted, even if a pop happens in the same cycle.
- An MDU result with dest 0 is accepted (handshake completes) but not stored.
- A WB request with wb_dest 0 is treated as no request.
- Grant priority each cycle:
  1. Forced MDU: starvation guard fires and the head entry is valid.
  2. WB: wb_valid and wb_dest != 0.
  3. FIFO head: head entry is valid.
  4. Otherwise idle, rf_we = 0.
- rf_we/rf_dest/rf_data are combinational from the granted source.
- Pop rules:
  - The head is popped when it is granted.
  - An invalid (cancelled) head is popped in any cycle, without a write.
- Cancel: on a WB grant, every stored entry with dest == wb_dest has its valid bit cleared in that cycle. Entries stay counted until popped. WB is by definition younger in program order than any buffered MDU result.
- Push and pop in the same cycle leave fifo_count unchanged.

## Timing
- WB write: 0-cycle latency; rf_we is valid in the same cycle as wb_valid.
- MDU write: the earliest rf_we is the cycle after the push, when WB is idle.
- Register file write happens at the posedge ending the grant cycle.
- Reset (asynchronous, any time):
  - FIFO is emptied and all valid bits are cleared.
  - fifo_count = 0, busy = 0, starve counter = 0.
  - While reset is high: rf_we = 0, wb_stall = 0, mdu_ready = 0.
  - Flushed entries are never written afterwards.
- After reset deasserts, mdu_ready = 1 in the first cycle.

## Configuration
- RF_ARB_STARVE_GUARD_EN defined:
  - A starve counter increments each cycle in which the head is valid but not granted.
  - It clears on any FIFO-head grant or when the head becomes invalid or empty.
  - When the counter equals STARVE_LIMIT, the next cycle forces an MDU grant and asserts wb_stall. WB is not written that cycle; it holds and retries.
  - The counter then clears.
- RF_ARB_STARVE_GUARD_EN undefined:
  - No counter is built.
  - wb_stall is tied to 0.
  - The FIFO drains only in WB-idle cycles and may starve indefinitely.

## Test plan
- WB only: wb_valid=1, wb_dest=5, wb_data=0xA5 → same cycle rf_we=1, rf_dest=5, rf_data=0xA5; fifo_count stays 0.
- MDU idle drain: push dest 7, data 0x1234 in cycle N, WB idle → fifo_count=1 in N+1 with rf_we=1, rf_dest=7 in N+1; fifo_count=0 in N+2.
- Backpressure: with WB busy, push dest 8 then dest 10 → fifo_count=2, mdu_ready=0; a third mdu_valid is not accepted; after WB idles, writes go out in order 8 then 10.
- Cancel: FIFO holds dest 9 (0x11); WB writes dest 9 (0x22) → rf writes only 0x22 to r9; the entry is discarded next cycle with rf_we=0; fifo_count goes to 0.
- Starvation (macro defined, STARVE_LIMIT=4): FIFO holds dest 7; wb_valid=1 on dest 3 continuously → 4 WB grants, then one cycle with wb_stall=1 and rf_dest=7, then WB resumes. Without the macro, r7 is never written while WB stays busy.
- Reset mid-operation: fifo_count=2, then reset pulse → fifo_count=0, rf_we=0, mdu_ready=0 during reset; neither flushed entry is ever written.
